pico_control: RTL and testbench
===============================

Name: pico_control

Overview:
- Multi-cycle instruction sequencer for the pico-MIPS core. Drives the ALU's `func` code and sits at the opposite end of the ALU interface.
- Fetches from a synchronous-read program ROM and decodes each instruction into register-file addresses, immediate/operand-select, ALU function (shared ALU code definitions) and write-enable.
- Consumes the ALU zero flag to resolve conditional branches.
- One instruction every 4 cycles, 3 for non-writing instructions.

Parameters:
- PC_W, 8, program counter width; ROM depth is 2**PC_W.
- I_W, 20, instruction width. Fixed format: opcode[19:16], rd[15:13], rs[12:10], [9:8] ignored, imm[7:0].

Ports:
- clk  input  1  system clock, rising edge
- n_reset  input  1  asynchronous active-low reset
- go  input  1  start pulse; sampled only in IDLE
- instr  input  I_W  ROM data, valid the cycle after pc is presented
- zf  input  1  ALU zero flag, combinational from the current ALU operands
- pc  output  PC_W  program counter / ROM address
- alu_func  output  3  ALU function code (RA/RB/RADD/RSUB/RAND/ROR/RXOR/RMUL)
- imm_sel  output  1  1 = ALU operand B from imm, 0 = from register rs
- imm  output  8  IR imm field
- rd_addr  output  3  destination and ALU operand A register
- rs_addr  output  3  ALU operand B register
- reg_we  output  1  register-file write strobe, writes ALU result into rd
- halted  output  1  high in HALT state

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=0, IR=0 (NOP), reg_we=0, halted=0.
  - Decoded outputs follow NOP: alu_func=RA, imm_sel=0, addresses 0, imm 0.
- State sequence: IDLE -> FETCH -> DECODE -> EXEC -> {WB -> FETCH | FETCH | HALT}.
- IDLE: wait for go=1, then go to FETCH; go is ignored in every other state.
- FETCH: pc held stable for the ROM read.
- DECODE: IR <= instr.
- alu_func, imm_sel, imm, rd_addr and rs_addr are decoded combinationally from IR and hold through EXEC and WB.
- Opcodes (func / imm_sel / writes):
  - 0 NOP: RA / 0 / no
  - 1 ADD: RADD / 0 / yes
  - 2 ADDI: RADD / 1 / yes
  - 3 SUB: RSUB / 0 / yes
  - 4 SUBI: RSUB / 1 / yes
  - 5 MUL: RMUL / 0 / yes
  - 6 MULI: RMUL / 1 / yes
  - 7 AND: RAND / 0 / yes
  - 8 OR: ROR / 0 / yes
  - 9 XOR: RXOR / 0 / yes
  - 10 MOV: RB / 0 / yes
  - 11 LDI: RB / 1 / yes
  - 12 BEQ: RSUB / 0 / no
  - 13 BNE: RSUB / 0 / no
  - 14 JMP: RA / 0 / no
  - 15 HALT: RA / 0 / no
- EXEC, writing opcodes: go to WB; pc unchanged.
- EXEC, BEQ/BNE: zf sampled at the EXEC clock edge.
  - Taken (BEQ&zf, BNE&!zf): pc <= pc + sign_extend(imm), modulo 2**PC_W; relative to the branch's own address.
  - Not taken: pc <= pc+1.
  - Next state FETCH.
- EXEC, JMP: pc <= imm zero-extended/truncated to PC_W; next FETCH.
- EXEC, NOP: pc <= pc+1; next FETCH.
- EXEC, HALT: go to HALT; pc not incremented.
- WB: reg_we=1 for exactly this one cycle; pc <= pc+1; next FETCH. reg_we is 0 in all other states.
- HALT: halted=1, reg_we=0, pc frozen. Leave only via reset; go is ignored.
- pc increments wrap from 2**PC_W-1 to 0.
- Reset asserted mid-WB drops reg_we in the same cycle, with no clock edge needed.
- A zero-offset taken branch (imm=0) is a legal self-loop.

Test Plan:
- Reset low, then high with go=0 for 10 cycles -> pc=0, reg_we=0 throughout, state IDLE. Then go pulse -> FETCH next cycle.
- ROM[0]=ADDI r1,5 (0x2_2005) -> DECODE at cycle 2, EXEC drives alu_func=RADD, imm_sel=1, rd_addr=1, imm=5. reg_we=1 only in cycle 4, then pc=1.
- BEQ at pc=0x10 with imm=0xFC, zf=1 -> pc=0x0C, no reg_we. Same instruction with zf=0 -> pc=0x11. BNE with zf=0, imm=0x03 -> pc=0x13.
- JMP imm=0x80 -> pc=0x80. NOP at pc=0xFF -> pc wraps to 0x00.
- HALT at pc=7 -> halted=1 and pc stays 7 for 20 cycles with go toggling. Reset then go -> normal fetch from 0.
- n_reset pulsed low during the WB of a MUL -> reg_we deasserts asynchronously; pc=0, state IDLE, halted=0.

Source files
------------

// File: rtl/pico_control_if.sv
// rtl/pico_control_if.sv - ROM and ALU/register-file bus between pico_control and the datapath
interface pico_control_if #(
  parameter int PC_W = 8,
  parameter int I_W  = 20
);
  logic [PC_W-1:0] pc;
  logic [I_W-1:0]  instr;
  logic [2:0]      alu_func;
  logic            imm_sel;
  logic [7:0]      imm;
  logic [2:0]      rd_addr;
  logic [2:0]      rs_addr;
  logic            reg_we;
  logic            zf;

  modport master (
    output pc, alu_func, imm_sel, imm, rd_addr, rs_addr, reg_we,
    input  instr, zf
  );

  modport slave (
    input  pc, alu_func, imm_sel, imm, rd_addr, rs_addr, reg_we,
    output instr, zf
  );
endinterface

// File: rtl/pico_control.sv
// rtl/pico_control.sv - pico-MIPS multi-cycle sequencer: fetch, decode, branch resolve, write-back strobe
module pico_control #(
  parameter int PC_W = 8,
  parameter int I_W  = 20
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           go,
  pico_control_if.master bus,
  output logic           halted
);
  localparam logic [2:0] RA = 3'd0, RB = 3'd1, RADD = 3'd2, RSUB = 3'd3,
                         RAND = 3'd4, ROR = 3'd5, RXOR = 3'd6, RMUL = 3'd7;

  localparam logic [3:0] OP_BEQ = 4'd12, OP_BNE = 4'd13, OP_JMP = 4'd14, OP_HALT = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic            reg_we_q;
  // IR keeps opcode/rd/rs and imm; instruction bits [9:8] carry nothing
  logic [17:0]     ir;

  logic [3:0]      opcode;
  logic [7:0]      imm_f;
  logic [2:0]      func;
  logic            isel;
  logic            writes;
  logic            taken;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_tgt;

  assign opcode  = ir[17:14];
  assign imm_f   = ir[7:0];
  assign br_off  = PC_W'($signed(imm_f));
  assign jmp_tgt = PC_W'(imm_f);
  assign taken   = (opcode == OP_BEQ && bus.zf) || (opcode == OP_BNE && !bus.zf);

  always_comb begin
    func   = RA;
    isel   = 1'b0;
    writes = 1'b0;
    case (opcode)
      4'd1:  begin func = RADD; writes = 1'b1; end
      4'd2:  begin func = RADD; isel = 1'b1; writes = 1'b1; end
      4'd3:  begin func = RSUB; writes = 1'b1; end
      4'd4:  begin func = RSUB; isel = 1'b1; writes = 1'b1; end
      4'd5:  begin func = RMUL; writes = 1'b1; end
      4'd6:  begin func = RMUL; isel = 1'b1; writes = 1'b1; end
      4'd7:  begin func = RAND; writes = 1'b1; end
      4'd8:  begin func = ROR;  writes = 1'b1; end
      4'd9:  begin func = RXOR; writes = 1'b1; end
      4'd10: begin func = RB;   writes = 1'b1; end
      4'd11: begin func = RB;   isel = 1'b1; writes = 1'b1; end
      4'd12, 4'd13: func = RSUB;
      default: func = RA;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.alu_func = func;
  assign bus.imm_sel  = isel;
  assign bus.imm      = imm_f;
  assign bus.rd_addr  = ir[13:11];
  assign bus.rs_addr  = ir[10:8];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      pc_q     <= '0;
      ir       <= '0;
      reg_we_q <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (go) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= {bus.instr[19:10], bus.instr[7:0]};
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (writes) begin
            reg_we_q <= 1'b1;
            state    <= S_WB;
          end else begin
            case (opcode)
              OP_BEQ, OP_BNE: begin
                // branch offset is relative to the branch's own address
                pc_q  <= taken ? pc_q + br_off : pc_q + PC_W'(1);
                state <= S_FETCH;
              end
              OP_JMP: begin
                pc_q  <= jmp_tgt;
                state <= S_FETCH;
              end
              OP_HALT: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
              default: begin
                pc_q  <= pc_q + PC_W'(1);
                state <= S_FETCH;
              end
            endcase
          end
        end
        S_WB: begin
          reg_we_q <= 1'b0;
          pc_q     <= pc_q + PC_W'(1);
          state    <= S_FETCH;
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pico_control.sv
// tb/tb_pico_control.sv - randomized and directed bench for pico_control against an instruction-level model
module tb_pico_control;
  localparam logic [2:0] RA = 3'd0, RB = 3'd1, RADD = 3'd2, RSUB = 3'd3,
                         RAND = 3'd4, ROR = 3'd5, RXOR = 3'd6, RMUL = 3'd7;
  localparam logic [19:0] I_HALT = 20'hF0000;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic go = 1'b0;
  logic halted;
  logic zf_drv = 1'b0;
  logic zf_force = 1'b0;
  bit   zf_force_en = 1'b0;
  bit   cmp_en = 1'b0;

  logic [19:0] rom [256];
  logic [19:0] rom_q;

  int checks = 0;
  int errors = 0;

  pico_control_if bus ();

  pico_control dut (
    .clk     (clk),
    .n_reset (n_reset),
    .go      (go),
    .bus     (bus),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[bus.pc];
  assign bus.instr = rom_q;
  assign bus.zf    = zf_drv;

  always @(negedge clk) zf_drv = zf_force_en ? zf_force : 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec tables
  function automatic logic [2:0] e_func(input logic [3:0] op);
    case (op)
      4'd1, 4'd2:                return RADD;
      4'd3, 4'd4, 4'd12, 4'd13:  return RSUB;
      4'd5, 4'd6:                return RMUL;
      4'd7:                      return RAND;
      4'd8:                      return ROR;
      4'd9:                      return RXOR;
      4'd10, 4'd11:              return RB;
      default:                   return RA;
    endcase
  endfunction

  function automatic bit e_imm(input logic [3:0] op);
    return (op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd11);
  endfunction

  function automatic bit e_wr(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd11);
  endfunction

  function automatic int wrap(input int x);
    return ((x % 256) + 256) % 256;
  endfunction

  function automatic int next_pc(input logic [19:0] ins, input int pc, input logic z);
    int off;
    logic [3:0] op;
    op  = ins[19:16];
    off = (ins[7:0] >= 8'd128) ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
    case (op)
      4'd12:   return z  ? wrap(pc + off) : wrap(pc + 1);
      4'd13:   return !z ? wrap(pc + off) : wrap(pc + 1);
      4'd14:   return int'(ins[7:0]);
      4'd15:   return pc;
      default: return wrap(pc + 1);
    endcase
  endfunction

  // Instruction-level model: m_cyc counts cycles into the current instruction
  int          m_pc;
  int          m_cyc;
  bit          m_run;
  bit          m_halt;
  logic [19:0] m_ir;
  logic [3:0]  m_op;
  assign m_op = m_ir[19:16];

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_pc <= 0; m_cyc <= 0; m_run <= 1'b0; m_halt <= 1'b0; m_ir <= '0;
    end else if (m_run) begin
      case (m_cyc)
        0: m_cyc <= 1;
        1: begin m_ir <= rom[m_pc]; m_cyc <= 2; end
        2: begin
          if (e_wr(m_op)) m_cyc <= 3;
          else begin
            m_pc <= next_pc(m_ir, m_pc, bus.zf);
            if (m_op == 4'd15) begin m_run <= 1'b0; m_halt <= 1'b1; end
            else m_cyc <= 0;
          end
        end
        default: begin m_pc <= wrap(m_pc + 1); m_cyc <= 0; end
      endcase
    end else if (!m_halt && go) begin
      m_run <= 1'b1;
      m_cyc <= 0;
    end
  end

  always @(negedge clk) begin
    if (n_reset && cmp_en) begin
      chk("pc", 32'(bus.pc), m_pc);
      chk("reg_we", 32'(bus.reg_we), 32'(m_run && m_cyc == 3));
      chk("halted", 32'(halted), 32'(m_halt));
      if (m_run && m_cyc >= 2) begin
        chk("alu_func", 32'(bus.alu_func), 32'(e_func(m_op)));
        chk("imm_sel", 32'(bus.imm_sel), 32'(e_imm(m_op)));
        chk("imm", 32'(bus.imm), 32'(m_ir[7:0]));
        chk("rd_addr", 32'(bus.rd_addr), 32'(m_ir[15:13]));
        chk("rs_addr", 32'(bus.rs_addr), 32'(m_ir[12:10]));
      end
    end
  end

  task automatic do_reset();
    go = 1'b0;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic wait_halt(input int bound);
    int n = 0;
    while (!halted && n < bound) begin @(negedge clk); n++; end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic wait_pc(input logic [7:0] target, input int bound);
    int n = 0;
    while (bus.pc !== target && n < bound) begin @(negedge clk); n++; end
    chk("pc_reached", 32'(bus.pc), 32'(target));
  endtask

  task automatic run_branch(input logic z, input logic [7:0] exp_pc);
    do_reset();
    zf_force = z;
    zf_force_en = 1'b1;
    pulse_go();
    wait_halt(60);
    chk("branch_pc", 32'(bus.pc), 32'(exp_pc));
    chk("branch_no_we", 32'(bus.reg_we), 32'd0);
  endtask

  initial begin
    clear_rom();
    rom[0] = 20'h22005;
    rom[1] = I_HALT;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    cmp_en = 1'b1;

    chk("rst_func", 32'(bus.alu_func), 32'(RA));
    chk("rst_imm_sel", 32'(bus.imm_sel), 32'd0);
    chk("rst_rd", 32'(bus.rd_addr), 32'd0);
    chk("rst_rs", 32'(bus.rs_addr), 32'd0);
    chk("rst_imm", 32'(bus.imm), 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("idle_pc", 32'(bus.pc), 32'd0);
      chk("idle_we", 32'(bus.reg_we), 32'd0);
    end

    // ADDI r1,5
    pulse_go();
    chk("fetch_pc", 32'(bus.pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("addi_func", 32'(bus.alu_func), 32'(RADD));
    chk("addi_imm_sel", 32'(bus.imm_sel), 32'd1);
    chk("addi_rd", 32'(bus.rd_addr), 32'd1);
    chk("addi_imm", 32'(bus.imm), 32'd5);
    chk("addi_exec_we", 32'(bus.reg_we), 32'd0);
    @(negedge clk);
    chk("addi_wb_we", 32'(bus.reg_we), 32'd1);
    chk("addi_wb_pc", 32'(bus.pc), 32'd0);
    @(negedge clk);
    chk("addi_post_we", 32'(bus.reg_we), 32'd0);
    chk("addi_post_pc", 32'(bus.pc), 32'd1);
    wait_halt(20);

    // Conditional branches
    clear_rom();
    rom[0] = 20'hE0010;
    rom[8'h10] = 20'hC00FC;
    rom[8'h0C] = I_HALT;
    rom[8'h11] = I_HALT;
    run_branch(1'b1, 8'h0C);
    run_branch(1'b0, 8'h11);
    rom[8'h10] = 20'hD0003;
    rom[8'h13] = I_HALT;
    run_branch(1'b0, 8'h13);

    // Zero-offset taken branch spins in place
    rom[8'h10] = 20'hC0000;
    do_reset();
    zf_force = 1'b1;
    pulse_go();
    repeat (30) @(negedge clk);
    chk("selfloop_pc", 32'(bus.pc), 32'h10);
    chk("selfloop_halted", 32'(halted), 32'd0);
    zf_force_en = 1'b0;

    // JMP and pc wrap
    clear_rom();
    rom[0] = 20'hE0080;
    rom[8'h80] = 20'hE00FF;
    do_reset();
    pulse_go();
    wait_pc(8'h80, 10);
    wait_pc(8'hFF, 10);
    wait_pc(8'h00, 10);

    // HALT holds against go
    clear_rom();
    rom[7] = I_HALT;
    do_reset();
    pulse_go();
    wait_halt(60);
    chk("halt_pc", 32'(bus.pc), 32'd7);
    repeat (20) begin
      @(negedge clk);
      go = ~go;
      chk("halt_hold_pc", 32'(bus.pc), 32'd7);
      chk("halt_hold", 32'(halted), 32'd1);
    end
    go = 1'b0;
    do_reset();
    chk("halt_cleared", 32'(halted), 32'd0);
    pulse_go();
    wait_pc(8'h01, 10);

    // Async reset during MUL write-back
    clear_rom();
    rom[0] = 20'h54C00;
    rom[1] = I_HALT;
    do_reset();
    pulse_go();
    @(negedge clk);
    @(negedge clk);
    chk("mul_func", 32'(bus.alu_func), 32'(RMUL));
    chk("mul_rd", 32'(bus.rd_addr), 32'd2);
    chk("mul_rs", 32'(bus.rs_addr), 32'd3);
    @(negedge clk);
    chk("mul_wb_we", 32'(bus.reg_we), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    chk("async_we", 32'(bus.reg_we), 32'd0);
    chk("async_pc", 32'(bus.pc), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_pc", 32'(bus.pc), 32'd0);
    pulse_go();
    wait_halt(20);
    chk("post_rst_halt_pc", 32'(bus.pc), 32'd1);

    // Random programs with random zf and go noise
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < 256; i++) rom[i] = 20'($urandom);
      do_reset();
      pulse_go();
      repeat (150) begin
        @(negedge clk);
        go = 1'($urandom_range(0, 1));
      end
      go = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
